router_port_drain: RTL and testbench

- Egress stage placed directly downstream of one router output FIFO; one instance per output port.
- Pulls packet bytes out of the FIFO using vld_out / read_enb.
- Reframes each packet as a valid/ready byte stream with start-of-packet and end-of-packet markers.
- Checks packet parity, counts good and bad packets, and flushes cleanly when the FIFO is soft-reset.

---
 rtl/router_port_drain_if.sv | 37 +++
 rtl/router_port_drain.sv | 159 +++++++++++++++
 tb/tb_router_port_drain.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_port_drain_if.sv
// Bundles the FIFO-side read handshake, the egress byte stream and the
// per-port status/counter outputs of one router output port drain.
interface router_port_drain_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  // FIFO side
  logic              vld_out;
  logic [DATA_W-1:0] data_out;
  logic              soft_reset;
  logic              read_enb;
  // Egress stream
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_sop;
  logic              m_eop;
  logic              m_err;
  // Status
  logic              pkt_abort;
  logic [CNT_W-1:0]  pkt_cnt;
  logic [CNT_W-1:0]  err_cnt;

  // Drain block view
  modport master (
    input  vld_out, data_out, soft_reset, m_ready,
    output read_enb, m_data, m_valid, m_sop, m_eop, m_err,
           pkt_abort, pkt_cnt, err_cnt
  );

  // Environment view (FIFO + downstream consumer)
  modport slave (
    output vld_out, data_out, soft_reset, m_ready,
    input  read_enb, m_data, m_valid, m_sop, m_eop, m_err,
           pkt_abort, pkt_cnt, err_cnt
  );
endinterface

// File: rtl/router_port_drain.sv
// Router output-port drain: pulls packet bytes from the port FIFO, reframes
// them as a valid/ready stream with sop/eop markers through a 2-entry skid
// buffer, checks packet parity and counts good/bad packets.
module router_port_drain #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                clock,
  input  logic                reset,
  router_port_drain_if.master bus
);

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    logic              err;
  } beat_t;

  state_t            state_q, state_d;
  logic [6:0]        rem_q, rem_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              inflight_q;
  beat_t             ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]        occ_q, occ_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;
  logic              abort_q, abort_d;

  logic              want, rd, pop, push;
  logic [2:0]        fill;
  beat_t             push_beat;

  // Read gating: room is judged on occupancy after this cycle's pop plus the
  // byte already in flight, so one byte per cycle flows without overflow.
  always_comb begin
    pop  = (occ_q != 2'd0) & bus.m_ready;
    fill = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    want = (state_q == IDLE) | ((state_q == BODY) & (rem_q != 7'd0));
    rd   = ~reset & ~bus.soft_reset & bus.vld_out & want & (fill < 3'd2);
  end

  // Packet FSM: header decode, remaining-byte count, parity accumulation.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    acc_d     = acc_q;
    push      = 1'b0;
    push_beat = '0;
    unique case (state_q)
      IDLE: begin
        if (rd) state_d = HDR;
      end
      HDR: begin
        if (inflight_q) begin
          push           = 1'b1;
          push_beat.data = bus.data_out;
          push_beat.sop  = 1'b1;
          rem_d          = {1'b0, bus.data_out[7:2]} + 7'd1;
          acc_d          = bus.data_out;
          state_d        = BODY;
        end
      end
      BODY: begin
        if (rd) rem_d = rem_q - 7'd1;
        if (inflight_q) begin
          push           = 1'b1;
          push_beat.data = bus.data_out;
          if (rem_q == 7'd0) begin
            push_beat.eop = 1'b1;
            push_beat.err = ((acc_q ^ bus.data_out) != '0);
            acc_d         = '0;
            state_d       = IDLE;
          end else begin
            acc_d = acc_q ^ bus.data_out;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.soft_reset) begin
      state_d = IDLE;
      rem_d   = '0;
      acc_d   = '0;
      push    = 1'b0;
    end
  end

  // Skid buffer: entry 0 is the head; a pop shifts entry 1 down before the
  // push lands, so simultaneous push/pop keeps order and occupancy.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    if (pop) begin
      ent0_d = ent1_q;
      occ_d  = occ_q - 2'd1;
    end
    if (push) begin
      if (occ_d == 2'd0) ent0_d = push_beat;
      else               ent1_d = push_beat;
      occ_d = occ_d + 2'd1;
    end
    if (bus.soft_reset) occ_d = '0;
  end

  // Saturating good/bad counters on delivered eop beats; abort detection.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    if (pop & ent0_q.eop & ~bus.soft_reset) begin
      if (ent0_q.err) begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
      end else begin
        if (pkt_cnt_q != '1) pkt_cnt_d = pkt_cnt_q + 1'b1;
      end
    end
    abort_d = bus.soft_reset & ((state_q != IDLE) | (occ_q != 2'd0) | inflight_q);
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      acc_q      <= '0;
      inflight_q <= 1'b0;
      ent0_q     <= '0;
      ent1_q     <= '0;
      occ_q      <= '0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      acc_q      <= acc_d;
      inflight_q <= rd;
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
      occ_q      <= occ_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
      abort_q    <= abort_d;
    end
  end

  assign bus.read_enb  = rd;
  assign bus.m_valid   = (occ_q != 2'd0);
  assign bus.m_data    = ent0_q.data;
  assign bus.m_sop     = ent0_q.sop & bus.m_valid;
  assign bus.m_eop     = ent0_q.eop & bus.m_valid;
  assign bus.m_err     = ent0_q.err & bus.m_valid;
  assign bus.pkt_abort = abort_q;
  assign bus.pkt_cnt   = pkt_cnt_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_router_port_drain.sv
// Directed + randomized bench for router_port_drain. A queue models the port
// FIFO, a second queue holds the expected stream beats computed from the
// packet rules, and counters are tracked with saturation at the bench width.
module tb_router_port_drain;
  localparam int DW   = 8;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  router_port_drain_if #(.DATA_W(DW), .CNT_W(CW)) bus ();
  router_port_drain #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  fifo_q[$];
  logic [10:0] exp_q[$];
  int          exp_pkt = 0, exp_err = 0;
  int          outst = 0, nreads = 0, npops = 0, aborts = 0;
  logic        vgate = 1'b1;
  logic        hold_prev = 1'b0;
  logic [10:0] held_beat = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Queue one packet: header {L, addr}, payload, parity (optionally corrupted).
  task automatic send(input logic [1:0] addr, input logic [7:0] pl[$], input logic [7:0] flip);
    int         len;
    logic [7:0] hdr, x;
    len = pl.size();
    hdr = {len[5:0], addr};
    x   = hdr;
    fifo_q.push_back(hdr);
    exp_q.push_back({hdr, 3'b100});
    foreach (pl[i]) begin
      x ^= pl[i];
      fifo_q.push_back(pl[i]);
      exp_q.push_back({pl[i], 3'b000});
    end
    fifo_q.push_back(x ^ flip);
    exp_q.push_back({x ^ flip, 2'b01, flip != 8'h00});
    bus.vld_out = vgate;
  endtask

  // One clock: sample at negedge, score, then update FIFO model after the edge.
  task automatic tick();
    logic        re, pop, sr;
    logic [10:0] beat, e;
    @(negedge clock);
    re   = bus.read_enb;
    pop  = bus.m_valid & bus.m_ready;
    sr   = bus.soft_reset;
    beat = {bus.m_data, bus.m_sop, bus.m_eop, bus.m_err};
    if (bus.pkt_abort) aborts++;
    if (hold_prev) begin
      check("hold_valid", bus.m_valid, 1);
      check("hold_beat", beat, held_beat);
    end
    hold_prev = bus.m_valid & ~bus.m_ready & ~sr;
    held_beat = beat;
    if (re) begin
      check("rd_needs_vld", bus.vld_out, 1);
      check("rd_room", ((outst - pop) < 2), 1);
      check("rd_in_sreset", sr, 0);
    end
    if (pop) begin
      check("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat", beat, e);
        npops++;
        if (e[1] && !sr) begin
          if (e[0]) begin if (exp_err < CMAX) exp_err++; end
          else      begin if (exp_pkt < CMAX) exp_pkt++; end
        end
      end
    end
    @(posedge clock);
    #1;
    if (re && fifo_q.size() != 0) begin
      nreads++;
      bus.data_out = fifo_q.pop_front();
    end else begin
      bus.data_out = 8'($urandom);
    end
    outst = outst + int'(re) - int'(pop);
    if (sr) begin
      outst = 0;
      fifo_q.delete();
      exp_q.delete();
    end
    bus.vld_out = (fifo_q.size() != 0) & vgate;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", exp_q.size() + fifo_q.size(), 0);
  endtask

  task automatic check_counts();
    check("pkt_cnt", bus.pkt_cnt, exp_pkt);
    check("err_cnt", bus.err_cnt, exp_err);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_read_enb"}, bus.read_enb, 0);
    check({tag, "_m_valid"}, bus.m_valid, 0);
    check({tag, "_m_data"}, bus.m_data, 0);
    check({tag, "_flags"}, {bus.m_sop, bus.m_eop, bus.m_err, bus.pkt_abort}, 0);
    check({tag, "_pkt_cnt"}, bus.pkt_cnt, 0);
    check({tag, "_err_cnt"}, bus.err_cnt, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pl[$];
    int n0, a0, n;

    reset = 1'b1;
    bus.vld_out = 1'b0;
    bus.data_out = '0;
    bus.soft_reset = 1'b0;
    bus.m_ready = 1'b0;
    #2;
    check_all_zero("reset");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    bus.m_ready = 1'b1;

    // 1: good packet, L=3
    n0 = nreads;
    pl = '{8'h11, 8'h22, 8'h33};
    send(2'd1, pl, 8'h00);
    drain(60);
    check("t1_reads", nreads - n0, 5);
    check("t1_pkt", bus.pkt_cnt, 1);
    check_counts();

    // 2: same packet, parity 0x0E
    send(2'd1, pl, 8'h03);
    drain(60);
    check("t2_err", bus.err_cnt, 1);
    check_counts();

    // 3: zero-length packet
    pl = {};
    n0 = npops;
    send(2'd2, pl, 8'h00);
    drain(40);
    check("t3_beats", npops - n0, 2);
    check_counts();

    // 4: downstream stall after beat 2, back-to-back packets
    pl = '{8'h11, 8'h22, 8'h33};
    n0 = npops;
    send(2'd1, pl, 8'h00);
    send(2'd1, pl, 8'h00);
    n = 0;
    while (npops - n0 < 2 && n < 40) begin tick(); n++; end
    check("t4_two_beats", npops - n0, 2);
    bus.m_ready = 1'b0;
    repeat (10) tick();
    check("t4_full_no_rd", bus.read_enb, 0);
    check("t4_full_valid", bus.m_valid, 1);
    bus.m_ready = 1'b1;
    drain(80);
    check("t4_beats", npops - n0, 10);
    check_counts();

    // 5: vld_out toggling during 6-byte payload
    pl = '{8'hA1, 8'h5B, 8'h3C, 8'hF0, 8'h0F, 8'h77};
    send(2'd3, pl, 8'h00);
    n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < 100) begin
      vgate = ~vgate;
      bus.vld_out = (fifo_q.size() != 0) & vgate;
      tick();
      n++;
    end
    vgate = 1'b1;
    check("t5_done", exp_q.size() + fifo_q.size(), 0);
    check_counts();

    // 6: soft reset after two payload bytes have landed
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    n0 = nreads;
    send(2'd0, pl, 8'h00);
    n = 0;
    while (nreads - n0 < 3 && n < 40) begin tick(); n++; end
    check("t6_reads", nreads - n0 >= 3, 1);
    tick();
    a0 = aborts;
    bus.soft_reset = 1'b1;
    tick();
    bus.soft_reset = 1'b0;
    check("t6_flushed", bus.m_valid, 0);
    tick();
    tick();
    check("t6_abort_once", aborts - a0, 1);
    check_counts();
    pl = '{8'hDE, 8'hAD};
    send(2'd2, pl, 8'h00);
    drain(40);
    check_counts();

    // soft reset while idle and empty: no abort pulse
    a0 = aborts;
    bus.soft_reset = 1'b1;
    tick();
    bus.soft_reset = 1'b0;
    tick();
    tick();
    check("idle_sreset_no_abort", aborts - a0, 0);

    // randomized packets, backpressure and FIFO gaps (counters saturate)
    for (int p = 0; p < 40; p++) begin
      pl = {};
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      send(2'($urandom), pl, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
      repeat ($urandom_range(0, 10)) begin
        bus.m_ready = ($urandom_range(0, 3) != 0);
        vgate = ($urandom_range(0, 4) != 0);
        bus.vld_out = (fifo_q.size() != 0) & vgate;
        tick();
      end
    end
    bus.m_ready = 1'b1;
    vgate = 1'b1;
    bus.vld_out = (fifo_q.size() != 0);
    drain(2000);
    check_counts();

    // asynchronous reset mid-packet
    pl = '{8'h10, 8'h20, 8'h30, 8'h40};
    n0 = nreads;
    send(2'd1, pl, 8'h00);
    n = 0;
    while (nreads - n0 < 3 && n < 40) begin tick(); n++; end
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("mid_reset");
    fifo_q.delete();
    exp_q.delete();
    outst = 0;
    exp_pkt = 0;
    exp_err = 0;
    hold_prev = 1'b0;
    bus.vld_out = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    pl = '{8'h55, 8'hAA, 8'h0C};
    send(2'd3, pl, 8'h00);
    drain(60);
    check("post_reset_pkt", bus.pkt_cnt, 1);
    check_counts();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
